// File: rtl/traffic_injector_if.sv
// Descriptor-fill and flit-injection signals between descriptor store, injector and router.
// The "slave" modport is the injector's view and "master" is the store/router side.
interface traffic_injector_if #(
    parameter int MAXVC   = 4,
    parameter int DST_W   = 6,
    parameter int VC_W    = 2,
    parameter int NFLIT_W = 4,
    parameter int CYC_W   = 16,
    parameter int DEPTH   = 8
);
    localparam int PEND_W = $clog2(DEPTH) + 1;

    logic               fill_valid;
    logic [DST_W-1:0]   fill_dst;
    logic [VC_W-1:0]    fill_vc;
    logic [NFLIT_W-1:0] fill_num_flit;
    logic [CYC_W-1:0]   fill_cycle;
    logic               fill_ready;
    logic [CYC_W-1:0]   in_cycle;
    logic [MAXVC-1:0]   can_inject;
    logic               flit_valid;
    logic               flit_head;
    logic               flit_tail;
    logic [DST_W-1:0]   flit_dst;
    logic [VC_W-1:0]    flit_vc;
    logic [NFLIT_W-1:0] flit_seq;
    logic [PEND_W-1:0]  pending;
    logic               done;
    logic               err;

    modport master (
        output fill_valid, fill_dst, fill_vc, fill_num_flit, fill_cycle, in_cycle, can_inject,
        input  fill_ready, flit_valid, flit_head, flit_tail, flit_dst, flit_vc, flit_seq,
               pending, done, err
    );

    modport slave (
        input  fill_valid, fill_dst, fill_vc, fill_num_flit, fill_cycle, in_cycle, can_inject,
        output fill_ready, flit_valid, flit_head, flit_tail, flit_dst, flit_vc, flit_seq,
               pending, done, err
    );
endinterface

// File: rtl/traffic_injector.sv
// Queues packet descriptors in order and serialises each into head/body/tail flits once released;
// first flit 3 edges after the write edge, 1 flit/cycle, stalls in place while can_inject[vc] is low.
module traffic_injector #(
    parameter int MAXVC   = 4,
    parameter int DST_W   = 6,
    parameter int VC_W    = 2,
    parameter int NFLIT_W = 4,
    parameter int CYC_W   = 16,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    traffic_injector_if.slave  io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DST_W-1:0]   dst;
        logic [VC_W-1:0]    vc;
        logic [NFLIT_W-1:0] nflit;
        logic [CYC_W-1:0]   cycle;
    } desc_t;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SEND = 2'd2} state_t;

    state_t              state_q, state_d;
    desc_t               mem [DEPTH];
    desc_t               cur_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [NFLIT_W-1:0]  seq_q;
    logic [2**VC_W-1:0]  can_ext;
    logic                full, empty, last, latch, fire, pop, wr_en, bad_wr;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign last  = (seq_q == cur_q.nflit - NFLIT_W'(1));
    assign pop   = fire && last;
    // A pop frees the slot, so a same-cycle write is legal even when full.
    assign wr_en  = io.fill_valid && (io.fill_num_flit != '0) && (!full || pop);
    assign bad_wr = io.fill_valid && !wr_en;

    assign io.fill_ready = !full;
    assign io.pending    = count_q;
    assign io.done       = empty && (state_q == S_IDLE) && !io.flit_valid;

    always_comb begin
        can_ext = '0;
        can_ext[MAXVC-1:0] = io.can_inject;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: if (!empty) begin
                latch   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (io.in_cycle >= cur_q.cycle) state_d = S_SEND;
            S_SEND: if (can_ext[cur_q.vc]) begin
                fire = 1'b1;
                if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {io.fill_dst, io.fill_vc, io.fill_num_flit, io.fill_cycle};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cur_q         <= '0;
            seq_q         <= '0;
            io.err        <= 1'b0;
            io.flit_valid <= 1'b0;
            io.flit_head  <= 1'b0;
            io.flit_tail  <= 1'b0;
            io.flit_dst   <= '0;
            io.flit_vc    <= '0;
            io.flit_seq   <= '0;
        end else begin
            state_q       <= state_d;
            io.flit_valid <= fire;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !wr_en) count_q <= count_q - CW'(1);
            if (bad_wr) io.err <= 1'b1;
            if (latch) begin
                cur_q <= mem[rd_ptr_q];
                seq_q <= '0;
            end
            if (fire) begin
                io.flit_head <= (seq_q == '0);
                io.flit_tail <= last;
                io.flit_dst  <= cur_q.dst;
                io.flit_vc   <= cur_q.vc;
                io.flit_seq  <= seq_q;
                seq_q        <= last ? '0 : seq_q + NFLIT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_traffic_injector.sv
// Bench for traffic_injector: directed scenarios plus a randomized run against a packet-level model.
module tb_traffic_injector;
    localparam int MAXVC = 4, DST_W = 6, VC_W = 2, NFLIT_W = 4, CYC_W = 16, DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    traffic_injector_if #(.MAXVC(MAXVC), .DST_W(DST_W), .VC_W(VC_W), .NFLIT_W(NFLIT_W),
                          .CYC_W(CYC_W), .DEPTH(DEPTH)) bus ();

    traffic_injector #(.MAXVC(MAXVC), .DST_W(DST_W), .VC_W(VC_W), .NFLIT_W(NFLIT_W),
                       .CYC_W(CYC_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] dst;
        logic [1:0] vc;
        logic [3:0] seq;
        logic       head;
        logic       tail;
        int         rel;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fill_valid    = 1'b0;
        bus.fill_dst      = '0;
        bus.fill_vc       = '0;
        bus.fill_num_flit = '0;
        bus.fill_cycle    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        bus.in_cycle   = '0;
        bus.can_inject = '1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic fill(input int dst, input int vc, input int n, input int cyc);
        bus.fill_valid    = 1'b1;
        bus.fill_dst      = DST_W'(dst);
        bus.fill_vc       = VC_W'(vc);
        bus.fill_num_flit = NFLIT_W'(n);
        bus.fill_cycle    = CYC_W'(cyc);
        tick();
        bus.fill_valid    = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst = 1'b1;
        idle_inputs();
        bus.in_cycle   = '0;
        bus.can_inject = '1;
        tick();
        tick();
        obs = {bus.flit_valid, bus.flit_head, bus.flit_tail, bus.err, bus.flit_dst, bus.flit_vc,
               bus.flit_seq, bus.pending, bus.fill_ready, bus.done};
        checks++;
        if (obs !== 22'd3) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", obs, 22'd3);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.flit_valid, bus.pending, bus.fill_ready, bus.done} !== 7'b0_0000_11) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b pending=%0d ready=%b done=%b",
                     bus.flit_valid, bus.pending, bus.fill_ready, bus.done);
        end
    endtask

    task automatic test_basic();
        logic exp_v;
        do_reset();
        bus.in_cycle = 16'd100;
        fill(5, 1, 3, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = (i >= 2 && i <= 4);
            checks++;
            if (bus.flit_valid !== exp_v || (exp_v && {bus.flit_head, bus.flit_tail, bus.flit_dst,
                bus.flit_vc, bus.flit_seq} !== {i == 2, i == 4, 6'd5, 2'd1, 4'(i - 2)})) begin
                errors++;
                $display("FAIL basic_flit[%0d]: valid=%b h=%b t=%b dst=%0d vc=%0d seq=%0d want valid=%b seq=%0d",
                         i, bus.flit_valid, bus.flit_head, bus.flit_tail, bus.flit_dst, bus.flit_vc,
                         bus.flit_seq, exp_v, i - 2);
            end
            checks++;
            if (bus.pending !== 4'((i < 4) ? 1 : 0) || bus.done !== (i == 5)) begin
                errors++;
                $display("FAIL basic_status[%0d]: pending=%0d done=%b want pending=%0d done=%b",
                         i, bus.pending, bus.done, (i < 4) ? 1 : 0, i == 5);
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        bus.in_cycle = 16'd10;
        fill(7, 0, 1, 20);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.flit_valid !== 1'b0) begin
                errors++;
                $display("FAIL release_early[%0d]: valid=%b want 0", i, bus.flit_valid);
            end
        end
        bus.in_cycle = 16'd19;
        tick();
        bus.in_cycle = 16'd20;
        tick();
        checks++;
        if (bus.flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_same_edge: valid=%b want 0", bus.flit_valid);
        end
        tick();
        checks++;
        if ({bus.flit_valid, bus.flit_head, bus.flit_tail, bus.flit_dst} !== {3'b111, 6'd7}) begin
            errors++;
            $display("FAIL release_flit: valid=%b h=%b t=%b dst=%0d want 1 1 1 7",
                     bus.flit_valid, bus.flit_head, bus.flit_tail, bus.flit_dst);
        end
    endtask

    task automatic test_credit_stall();
        int exp_seq [10];
        exp_seq = '{-1, -1, 0, 1, -1, -1, -1, 2, 3, -1};
        do_reset();
        bus.in_cycle = 16'd100;
        fill(9, 2, 4, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.flit_valid !== (exp_seq[i] >= 0) || (exp_seq[i] >= 0 &&
                {bus.flit_seq, bus.flit_vc, bus.flit_tail} !== {4'(exp_seq[i]), 2'd2, exp_seq[i] == 3})) begin
                errors++;
                $display("FAIL credit_stall[%0d]: valid=%b seq=%0d tail=%b want seq %0d (-1 = none)",
                         i, bus.flit_valid, bus.flit_seq, bus.flit_tail, exp_seq[i]);
            end
            if (i == 3) bus.can_inject = 4'b1011;
            if (i == 6) bus.can_inject = 4'b1111;
        end
    endtask

    task automatic test_overflow();
        int got [$];
        do_reset();
        bus.in_cycle   = 16'd100;
        bus.can_inject = 4'b0000;
        for (int i = 0; i < 8; i++) fill(40 + i, 0, 1, 0);
        checks++;
        if ({bus.pending, bus.fill_ready, bus.err} !== {4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL overflow_full: pending=%0d ready=%b err=%b want 8 0 0",
                     bus.pending, bus.fill_ready, bus.err);
        end
        fill(50, 0, 1, 0);
        checks++;
        if ({bus.pending, bus.err} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL overflow_drop: pending=%0d err=%b want 8 1", bus.pending, bus.err);
        end
        bus.can_inject = 4'b0001;
        fill(51, 0, 1, 0);
        checks++;
        if ({bus.flit_valid, bus.flit_tail, bus.flit_dst, bus.pending} !== {2'b11, 6'd40, 4'd8}) begin
            errors++;
            $display("FAIL overflow_concurrent: valid=%b tail=%b dst=%0d pending=%0d want 1 1 40 8",
                     bus.flit_valid, bus.flit_tail, bus.flit_dst, bus.pending);
        end
        bus.can_inject = 4'b1111;
        for (int t = 0; t < 100 && got.size() < 8; t++) begin
            tick();
            if (bus.flit_valid) got.push_back(int'(bus.flit_dst));
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL overflow_drain_count: got %0d packets want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] != ((i < 7) ? 41 + i : 51)) begin
                    errors++;
                    $display("FAIL overflow_order[%0d]: dst=%0d want %0d", i, got[i], (i < 7) ? 41 + i : 51);
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.in_cycle   = 16'd100;
        bus.can_inject = 4'b0000;
        fill(3, 0, 2, 0);
        checks++;
        if ({bus.err, bus.pending} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL illegal_pre: err=%b pending=%0d want 0 1", bus.err, bus.pending);
        end
        fill(4, 1, 0, 0);
        checks++;
        if ({bus.err, bus.pending} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL illegal_nflit0: err=%b pending=%0d want 1 1", bus.err, bus.pending);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.in_cycle   = 16'd100;
        bus.can_inject = 4'b1111;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    for (int w = 0; w < 100 && !bus.fill_ready; w++) tick();
                    fill(i, i % 4, 1, 0);
                end
            end
            begin
                int got = 0;
                int last_t = 0;
                for (int t = 0; t < 300 && got < 20; t++) begin
                    tick();
                    if (bus.flit_valid) begin
                        checks++;
                        if ({bus.flit_head, bus.flit_tail, bus.flit_seq, bus.flit_dst} !==
                            {2'b11, 4'd0, 6'(got)} || (got > 0 && t - last_t != 3)) begin
                            errors++;
                            $display("FAIL wrap_pkt[%0d]: h=%b t=%b seq=%0d dst=%0d gap=%0d want 1 1 0 %0d gap 3",
                                     got, bus.flit_head, bus.flit_tail, bus.flit_seq, bus.flit_dst,
                                     t - last_t, got);
                        end
                        last_t = t;
                        got++;
                    end
                end
                checks++;
                if (got != 20) begin
                    errors++;
                    $display("FAIL wrap_count: got %0d packets want 20", got);
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        logic [21:0] obs;
        do_reset();
        bus.in_cycle   = 16'd100;
        bus.can_inject = 4'b1111;
        fill(12, 3, 5, 0);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus.flit_valid, bus.flit_seq} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b seq=%0d want 1 1", bus.flit_valid, bus.flit_seq);
        end
        #1 rst = 1'b1;
        #1;
        obs = {bus.flit_valid, bus.flit_head, bus.flit_tail, bus.err, bus.flit_dst, bus.flit_vc,
               bus.flit_seq, bus.pending, bus.fill_ready, bus.done};
        checks++;
        if (obs !== 22'd3) begin
            errors++;
            $display("FAIL midrst_async: got %h want %h", obs, 22'd3);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.flit_valid, bus.pending, bus.done} !== {1'b0, 4'd0, 1'b1}) begin
                errors++;
                $display("FAIL midrst_after[%0d]: valid=%b pending=%0d done=%b want 0 0 1",
                         i, bus.flit_valid, bus.pending, bus.done);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        exp_t expq [$];
        int sent, cnt, n, prev_in, prev2_in;
        logic [MAXVC-1:0] prev_can;
        logic fill_now;
        sent = 0;
        cnt  = 0;
        do_reset();
        bus.in_cycle = 16'd1000;
        prev_in = 1000;
        for (int c = 0; c < 4000; c++) begin
            if (sent == 40 && expq.size() == 0) break;
            checks++;
            if (bus.pending !== 4'(cnt) || bus.fill_ready !== (cnt < DEPTH)) begin
                errors++;
                $display("FAIL rand_status@%0d: pending=%0d ready=%b want %0d %b",
                         c, bus.pending, bus.fill_ready, cnt, cnt < DEPTH);
            end
            fill_now = (sent < 40 && cnt < DEPTH && $urandom_range(0, 2) == 0);
            bus.fill_valid = fill_now;
            if (fill_now) begin
                n = $urandom_range(1, 4);
                e.dst = 6'($urandom);
                e.vc  = 2'($urandom);
                e.rel = int'(bus.in_cycle) - 5 + $urandom_range(0, 20);
                bus.fill_dst      = e.dst;
                bus.fill_vc       = e.vc;
                bus.fill_num_flit = NFLIT_W'(n);
                bus.fill_cycle    = CYC_W'(e.rel);
                for (int s = 0; s < n; s++) begin
                    e.seq  = 4'(s);
                    e.head = (s == 0);
                    e.tail = (s == n - 1);
                    expq.push_back(e);
                end
                sent++;
            end
            bus.can_inject = MAXVC'($urandom) | MAXVC'($urandom);
            prev2_in = prev_in;
            prev_in  = int'(bus.in_cycle);
            prev_can = bus.can_inject;
            tick();
            bus.fill_valid = 1'b0;
            bus.in_cycle   = bus.in_cycle + 16'd1;
            if (fill_now) cnt++;
            if (bus.flit_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious@%0d: flit with nothing expected", c);
                end else begin
                    e = expq.pop_front();
                    if ({bus.flit_dst, bus.flit_vc, bus.flit_seq, bus.flit_head, bus.flit_tail} !==
                        {e.dst, e.vc, e.seq, e.head, e.tail} || prev_can[bus.flit_vc] !== 1'b1 ||
                        (e.head && prev2_in < e.rel)) begin
                        errors++;
                        $display("FAIL rand_flit@%0d: dst=%0d vc=%0d seq=%0d h=%b t=%b can=%b in=%0d want %0d %0d %0d %b %b rel=%0d",
                                 c, bus.flit_dst, bus.flit_vc, bus.flit_seq, bus.flit_head, bus.flit_tail,
                                 prev_can, prev2_in, e.dst, e.vc, e.seq, e.head, e.tail, e.rel);
                    end
                end
                if (bus.flit_tail) cnt--;
            end
        end
        tick();
        checks++;
        if (sent != 40 || expq.size() != 0 || bus.done !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rand_end: sent=%0d left=%0d done=%b err=%b want 40 0 1 0",
                     sent, expq.size(), bus.done, bus.err);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_release();
        test_credit_stall();
        test_overflow();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_injector.md
# traffic_injector

Per-router injection stage between the traffic descriptor store and the router's local injection port. Accepts packet descriptors (destination, VC, flit count, release cycle) into an in-order queue. Once a packet's release cycle is reached, it serialises the packet into head/body/tail flits. It emits at most one flit per cycle, gated by the router's per-VC `can_inject` credit indication.

## Interface
Parameters:
- `MAXVC`, 4, number of VCs; width of `can_inject`.
- `DST_W`, 6, destination router id width.
- `VC_W`, 2, VC index width; must satisfy 2^VC_W ≥ MAXVC.
- `NFLIT_W`, 4, flit-count width.
- `CYC_W`, 16, cycle counter width.
- `DEPTH`, 8, descriptor queue depth; power of two.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fill_valid` in 1: descriptor write strobe.
- `fill_dst` in DST_W: packet destination.
- `fill_vc` in VC_W: packet VC.
- `fill_num_flit` in NFLIT_W: flits in packet; 0 is illegal.
- `fill_cycle` in CYC_W: earliest injection cycle.
- `fill_ready` out 1: queue not full.
- `in_cycle` in CYC_W: current network cycle from the controller.
- `can_inject` in MAXVC: per-VC permission from the router.
- `flit_valid` out 1: registered flit strobe.
- `flit_head` out 1: first flit of packet.
- `flit_tail` out 1: last flit of packet.
- `flit_dst` out DST_W: destination of the emitted flit.
- `flit_vc` out VC_W: VC of the emitted flit.
- `flit_seq` out NFLIT_W: flit index within the packet, 0-based.
- `pending` out log2(DEPTH)+1: descriptors queued, including the one in flight.
- `done` out 1: queue empty, FSM idle, `flit_valid` = 0.
- `err` out 1: sticky; set on an overflow write or an illegal descriptor.

## Operation
- **Queue:** circular FIFO, `DEPTH` entries, with wr/rd pointers plus count.
  - Write when `fill_valid` & `fill_num_flit` ≠ 0 & not full.
  - `fill_valid` while full: write dropped, `err` ← 1.
  - `fill_valid` with `fill_num_flit` = 0: write dropped, `err` ← 1.
  - A write and a pop in the same cycle are both performed. The count is unchanged. This is legal even when full, because the pop frees the slot that the same-cycle write would need.
- **FSM:** IDLE, WAIT, SEND.
  - IDLE: if the queue is non-empty, latch the head entry into the working registers (dst, vc, nflit, cycle), clear seq, go to WAIT. The entry stays counted in `pending`.
  - WAIT: if `in_cycle` ≥ latched cycle (unsigned compare), go to SEND.
  - SEND: if `can_inject[vc]` = 1, register a flit:
    - `flit_valid` = 1.
    - `flit_head` = (seq == 0).
    - `flit_tail` = (seq == nflit−1).
    - `flit_dst`, `flit_vc`, `flit_seq` = seq.
    - seq ← seq+1.
  - On the tail flit, pop the queue and go to IDLE.
  - If `can_inject[vc]` = 0, hold seq and state, and drive `flit_valid` = 0.
- **Single-flit packet:** one flit, with head = tail = 1.
- **Ordering:** strictly in order. A blocked head packet stalls all later packets, including those on other VCs.
- **Pointers:** wrap modulo `DEPTH`. seq never exceeds nflit−1.

## Timing
- **Reset values:**
  - `flit_valid`, `flit_head`, `flit_tail`, `err` = 0.
  - `flit_dst`, `flit_vc`, `flit_seq` = 0.
  - `pending` = 0, `fill_ready` = 1, `done` = 1.
  - FSM = IDLE, pointers = 0.
- **Reset mid-operation:** the queue and any partially sent packet are discarded. No tail flit is emitted.
- **Minimum latency**, from `fill_valid` at edge N with an empty queue and a past release cycle:
  - edge N+1: the entry is written.
  - edge N+2: IDLE latches the entry.
  - edge N+3: WAIT sees the release condition.
  - edge N+4: SEND registers the first flit; `flit_valid` is high after edge N+4.
- **Throughput:** one flit per cycle within a packet. Two dead cycles (IDLE, WAIT) between the tail of one packet and the head of the next.
- **Sampling:** `can_inject` is sampled in the same cycle as the SEND decision. There is no lookahead.
- **Combinational outputs:**
  - `fill_ready` = !full, decoded from the registered count.
  - `done` = empty & IDLE & !`flit_valid`.
  - `pending` = count.

## Test plan
- **Basic packet:** after reset, fill dst=5, vc=1, nflit=3, cycle=0, with `can_inject`=4'b1111. Expect 3 consecutive flits starting edge N+4: seq 0/1/2, head on seq 0 only, tail on seq 2 only, dst=5, vc=1. Then `done` = 1 and `pending` = 0.
- **Release gating:** fill a packet with cycle=20 while `in_cycle`=10. Expect no `flit_valid` until `in_cycle` ≥ 20. Expect the first flit one edge after `in_cycle` reaches 20 in WAIT.
- **Credit stall:** 4-flit packet on vc=2; drop `can_inject[2]` for 3 cycles after seq 1. Expect a 3-cycle gap, then seq 2 and seq 3. No duplicated or skipped seq.
- **Overflow and concurrency:**
  - Fill 8 descriptors: `fill_ready` = 0 and `pending` = 8.
  - A 9th write with no pop: dropped, `err` = 1.
  - A write coincident with a tail pop: accepted, `pending` stays 8.
- **Illegal descriptor and wrap:**
  - Fill with nflit=0: `err` = 1, `pending` unchanged.
  - Stream 20 single-flit packets with dst = 0..19. Expect them emitted in order with head = tail = 1, and correct behaviour across pointer wrap.
- **Reset mid-packet:** assert `rst` after seq 1 of a 5-flit packet. Outputs return to reset values immediately. `pending` = 0, and no further flits appear after release.
